msk_reg_pipe: RTL and testbench
===============================

MSK_REG_PIPE -- requirements
Module: msk_reg_pipe

Interface
REQ-001 SHALL have parameter d, default 2, number of shares per masked bit (d >= 1).
REQ-002 SHALL have parameter count, default 1, number of masked bits carried (count >= 1).
REQ-003 SHALL have parameter DEPTH, default 2, number of pipeline stages (DEPTH >= 1).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous clear of all stage valid flags.
REQ-007 SHALL have port in_valid  input  1  upstream offers a sharing on in.
REQ-008 SHALL have port in_ready  output  1  block accepts in this cycle.
REQ-009 SHALL have port in  input  count*d  input sharing, same share layout as the other masked gadgets.
REQ-010 SHALL have port out_valid  output  1  out holds a valid sharing.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out this cycle.
REQ-012 SHALL have port out  output  count*d  output sharing, driven directly from last stage register.
REQ-013 SHALL have port occupancy  output  clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 SHALL hold per stage k (0 = input side, DEPTH-1 = output side): data register count*d bits and valid flag v[k].
REQ-015 SHALL compute acc[DEPTH] = out_ready, acc[k] = !v[k] | acc[k+1]; stage k may load iff acc[k] (bubble-collapsing elastic pipeline).
REQ-016 SHALL drive in_ready = acc[0] & !flush & !rst.
REQ-017 SHALL on acc[k]: v[0] <= in_valid & in_ready; v[k] <= v[k-1] for k > 0.
REQ-018 SHALL load stage-k data only when acc[k] and the source is valid; otherwise data holds (mux-feedback hold, no share recombination).
REQ-019 SHALL never combine, XOR or reorder bits of different shares; each out bit depends only on the same bit position of in.
REQ-020 SHALL give latency DEPTH cycles: sharing accepted at edge t appears with out_valid = 1 after edge t+DEPTH-1 when no stall occurs.
REQ-021 SHALL sustain throughput 1 sharing/cycle when out_ready is held high.
REQ-022 SHALL, when out_ready = 0 and all stages valid (full), drive in_ready = 0 and hold all data and flags unchanged.
REQ-023 SHALL accept and emit in the same cycle when full and out_ready = 1 (simultaneous push/pop keeps occupancy constant).
REQ-024 SHALL preserve order of accepted sharings; no drop, no duplication.
REQ-025 SHALL keep out stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL on flush = 1 clear all v[k] at the next edge, leave data registers unchanged, ignore in_valid that cycle; flush has priority over push/pop.
REQ-027 SHALL update occupancy registered, equal to the population count of v after each edge.
REQ-028 SHALL for DEPTH = 1 behave as a single enabled masked register with valid/ready handshake.

Reset
REQ-029 SHALL on rst = 1 clear all v[k], occupancy to 0, all data registers to 0, at the next rising edge.
REQ-030 SHALL drive in_ready = 0 while rst = 1; after rst deasserts in_ready = 1, out_valid = 0.
REQ-031 SHALL give rst priority over flush and any handshake; mid-operation reset discards in-flight sharings.

Verification (d=2, count=2, DEPTH=3)
REQ-032 SHALL cover streaming: out_ready = 1, push 4'hA,4'h5,4'h3 on consecutive cycles -> out_valid rises 3 cycles after first accept, outputs A,5,3 in consecutive cycles.
REQ-033 SHALL cover fill/stall: out_ready = 0, push 4'h1..4'h4 -> 3 accepted, occupancy = 3, in_ready = 0, 4th held by source; out_ready = 1 -> 1,2,3,4 emitted in order.
REQ-034 SHALL cover simultaneous push/pop when full: occupancy = 3, in_valid = out_ready = 1 -> occupancy stays 3, one sharing out, one in, every cycle.
REQ-035 SHALL cover bubble collapse: push 4'h7, idle, push 4'h8 with out_ready = 0 -> both sit in stages 2 and 1, occupancy = 2.
REQ-036 SHALL cover flush and reset mid-operation: occupancy = 2, assert flush (then separately rst) with in_valid = 1 -> next cycle occupancy = 0, out_valid = 0, input not captured.
REQ-037 SHALL check share independence: toggle only share-0 bits of in -> only share-0 bits of out change.

Source files
------------

// File: rtl/msk_reg_pipe.sv
// -----------------------------------------------------------------------------
// msk_reg_pipe
//   Elastic, bubble-collapsing register pipeline for masked sharings.
//   Each stage holds one sharing (count*d bits) plus a valid flag. Share bits
//   are only ever moved as a whole word from one stage to the next and are
//   never combined, so every output bit depends only on the same input bit
//   position.
//
// Parameters
//   d      : shares per masked bit (>= 1)
//   count  : masked bits carried (>= 1)
//   DEPTH  : number of pipeline stages (>= 1)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset (clears flags and data)
//   flush      : synchronous clear of all valid flags (data untouched)
//   in_valid   : upstream offers a sharing on in
//   in_ready   : pipeline accepts in this cycle
//   in         : input sharing
//   out_valid  : out holds a valid sharing
//   out_ready  : downstream accepts out this cycle
//   out        : output sharing, straight from the last stage register
//   occupancy  : registered count of valid stages
// -----------------------------------------------------------------------------
module msk_reg_pipe #(
    parameter int d     = 2,
    parameter int count = 1,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [count*d-1:0]             in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [count*d-1:0]             out,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int W  = count * d;
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_next;
    logic [DEPTH-1:0] acc;
    logic [DEPTH-1:0] src_valid;
    logic [DEPTH-1:0] load;
    logic [W-1:0]     data     [DEPTH];
    logic [W-1:0]     src_data [DEPTH];
    logic [OW-1:0]    occ_next;
    logic             push;

    // Stage k may advance when a bubble exists at or downstream of k, or the
    // consumer takes the head. Built with a running variable so the chain
    // does not read back its own output vector.
    always_comb begin
        logic a;
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        acc = '0;
        a   = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            a      = ~v[k] | a;
            acc[k] = a;
        end
    end

    assign in_ready = acc[0] & ~flush & ~rst;
    assign push     = in_valid & in_ready;

    // Source of each stage: the input port for stage 0, the previous stage
    // otherwise.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = push;
        src_data[0]  = in;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k] = v[k-1];
            src_data[k]  = data[k-1];
        end
    end

    // Flush clears the flags but must not disturb the data registers, so it
    // also gates the data load enables.
    always_comb begin
        v_next   = v;
        load     = '0;
        occ_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush) begin
                v_next[k] = 1'b0;
            end else if (acc[k]) begin
                v_next[k] = src_valid[k];
                load[k]   = src_valid[k];
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            occ_next = occ_next + OW'(v_next[k]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its source's pre-edge value and the shift does not ripple.
    always_ff @(posedge clk) begin
        if (rst) begin
            v         <= '0;
            occupancy <= '0;
            // NOTE: the data registers are cleared on reset as well, so no
            // stale share material is left visible on out after a reset.
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else begin
            v         <= v_next;
            occupancy <= occ_next;
            for (int k = 0; k < DEPTH; k++) begin
                if (load[k]) begin
                    data[k] <= src_data[k];
                end
            end
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out       = data[DEPTH-1];

endmodule

// File: tb/tb_msk_reg_pipe.sv
// -----------------------------------------------------------------------------
// tb_msk_reg_pipe
//   Directed and randomized stimulus for msk_reg_pipe (d=2, count=2, DEPTH=3).
//   The reference model tracks each accepted sharing as an item with a stage
//   position: the oldest item leaves when it sits at the last stage and the
//   consumer is ready; every other item advances one position when the slot
//   ahead of it is (or becomes) free.
// -----------------------------------------------------------------------------
module tb_msk_reg_pipe;

    localparam int D     = 2;
    localparam int CNT   = 2;
    localparam int DEPTH = 3;
    localparam int W     = CNT * D;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [OW-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] data;
        int           pos;
    } item_t;

    item_t q[$];

    msk_reg_pipe #(.d(D), .count(CNT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge(input logic [W-1:0] din, input bit ordy,
                              input bit fl, input bit rs, input bit accepted);
        item_t it;
        int    lim;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (ordy && q.size() > 0 && q[0].pos == DEPTH - 1) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) begin
                lim = (i == 0) ? DEPTH - 1 : q[i-1].pos - 1;
                it  = q[i];
                if (it.pos < lim) it.pos = it.pos + 1;
                q[i] = it;
            end
            if (accepted) begin
                it.data = din;
                it.pos  = 0;
                q.push_back(it);
            end
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model mid-cycle,
    // then cross the edge. Entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit iv, input logic [W-1:0] din, input bit ordy,
                         input bit fl, input bit rs, output bit accepted);
        bit exp_ready;
        bit exp_ov;
        in_valid  = iv;
        in_data   = din;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        @(negedge clk);
        exp_ready = !rs && !fl && (q.size() < DEPTH || ordy);
        exp_ov    = q.size() > 0 && q[0].pos == DEPTH - 1;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("occupancy", 32'(occupancy), 32'(q.size()));
        if (exp_ov) check("out", 32'(out_data), 32'(q[0].data));
        accepted = iv && exp_ready;
        model_edge(din, ordy, fl, rs, accepted);
        @(posedge clk);
        #1;
    endtask

    // Present a list of sharings as a source that holds each one until taken.
    task automatic send(input logic [W-1:0] items[$], input bit ordy, input int max_cycles);
        bit acc;
        int n = 0;
        while (items.size() > 0 && n < max_cycles) begin
            cycle(1'b1, items[0], ordy, 1'b0, 1'b0, acc);
            if (acc) void'(items.pop_front());
            n++;
        end
        check("send_done", 32'(items.size()), 32'd0);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, ordy, 1'b0, 1'b0, acc);
    endtask

    initial begin
        bit           acc;
        logic [W-1:0] src[$];
        logic [W-1:0] share0_mask;
        logic [W-1:0] base;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset, with an offered sharing that must be refused.
        cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b1, acc);
        check("reset_out_zero", 32'(out_data), 32'd0);
        idle(1, 1'b1);

        // Streaming at full rate.
        src = '{4'hA, 4'h5, 4'h3};
        send(src, 1'b1, 10);
        idle(4, 1'b1);

        // Fill and stall: the fourth sharing waits at the source.
        src = '{4'h1, 4'h2, 4'h3};
        send(src, 1'b0, 10);
        cycle(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, acc);
        check("full_refuses", 32'(acc), 32'd0);
        check("full_occupancy", 32'(occupancy), 32'd3);
        src = '{4'h4};
        send(src, 1'b1, 10);
        idle(4, 1'b1);

        // Simultaneous push/pop while full.
        src = '{4'h9, 4'hB, 4'hC};
        send(src, 1'b0, 10);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'(i + 2), 1'b1, 1'b0, 1'b0, acc);
            check("pushpop_accept", 32'(acc), 32'd1);
        end
        check("pushpop_occupancy", 32'(occupancy), 32'd3);
        idle(5, 1'b1);

        // Bubble collapse.
        cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, acc);
        idle(3, 1'b0);
        check("bubble_occupancy", 32'(occupancy), 32'd2);
        check("bubble_head", 32'(out_data), 32'h7);

        // Flush with a sharing offered: nothing captured.
        cycle(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, acc);
        check("flush_occupancy", 32'(occupancy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        idle(2, 1'b0);

        // Reset mid-operation with a sharing offered.
        src = '{4'h6, 4'hD};
        send(src, 1'b0, 10);
        idle(1, 1'b0);
        cycle(1'b1, 4'hE, 1'b1, 1'b0, 1'b1, acc);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_zero", 32'(out_data), 32'd0);
        idle(2, 1'b1);

        // Share independence: flip only share-0 bits (bit i*d of each masked bit).
        share0_mask = '0;
        for (int i = 0; i < CNT; i++) share0_mask[i*D] = 1'b1;
        base = 4'($urandom);
        src = '{base, base ^ share0_mask, base};
        send(src, 1'b1, 10);
        idle(4, 1'b1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0), 1'b0, acc);
        end
        idle(5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
